// File: rtl/cphy_lp_escape_tx.sv
// C-PHY Low-Power Escape Mode transmitter (master side, one lane).
// Sends escape entry, the entry command, LPDT bytes, ULPS and triggers as
// Spaced-One-Hot symbols on lines A/B/C. One LP symbol per TxClkEsc cycle.
// A^C is high on every Mark and low on every Space, so the receiver can
// rebuild its escape clock from the lines.
module cphy_lp_escape_tx #(
    parameter int WAKEUP_CYCLES = 16
) (
    input  logic       TxClkEsc,
    input  logic       Rst,
    input  logic       TxRequestEsc,
    input  logic       TxLpdtEsc,
    input  logic       TxUlpsEsc,
    input  logic [3:0] TxTriggerEsc,
    input  logic [7:0] TxDataEsc,
    input  logic       TxValidEsc,
    output logic       TxReadyEsc,
    output logic       LpA,
    output logic       LpB,
    output logic       LpC,
    output logic       Stopstate,
    output logic       UlpsActiveNot
);

    typedef enum logic [3:0] {
        ST_STOP,
        ST_ENT1,
        ST_ENT2,
        ST_ENT3,
        ST_ENT4,
        ST_CMD,
        ST_DATA_WAIT,
        ST_DATA,
        ST_ULPS_HOLD,
        ST_WAKE,
        ST_EXIT
    } state_t;

    typedef enum logic [1:0] {
        MODE_LPDT,
        MODE_ULPS,
        MODE_TRIG
    } mode_t;

    // Counter wide enough for WAKEUP_CYCLES-1, at least one bit.
    localparam int              WAKE_W    = (WAKEUP_CYCLES > 1) ? $clog2(WAKEUP_CYCLES) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKEUP_CYCLES - 1);

    // LP symbol levels as {A,B,C}
    localparam logic [2:0] LVL_STOP  = 3'b111;
    localparam logic [2:0] LVL_MARK1 = 3'b100;
    localparam logic [2:0] LVL_MARK0 = 3'b001;
    localparam logic [2:0] LVL_SPACE = 3'b000;

    state_t            stateReg, stateNext;
    mode_t             modeReg, modeNext;
    logic [3:0]        bitCntReg, bitCntNext;
    logic [7:0]        shiftReg, shiftNext;
    logic [WAKE_W-1:0] wakeCntReg, wakeCntNext;
    logic [2:0]        linesReg, linesNext;
    logic              stopReg, ulpsNotReg;
    logic              anyMode;
    logic [7:0]        trigCmd;
    logic [7:0]        entryCmd;

    // Line level for a given state; commands go out MSB first, data LSB first.
    // Even bit-counter values are Marks, odd values are the following Space.
    function automatic logic [2:0] lineLevel(input state_t st, input logic [7:0] sh,
                                             input logic [3:0] cnt);
        logic [2:0] lvl;
        lvl = LVL_SPACE;
        case (st)
            ST_STOP:      lvl = LVL_STOP;
            ST_ENT1:      lvl = LVL_MARK1;
            ST_ENT2:      lvl = LVL_SPACE;
            ST_ENT3:      lvl = LVL_MARK0;
            ST_ENT4:      lvl = LVL_SPACE;
            ST_CMD:       lvl = cnt[0] ? LVL_SPACE : (sh[7] ? LVL_MARK1 : LVL_MARK0);
            ST_DATA:      lvl = cnt[0] ? LVL_SPACE : (sh[0] ? LVL_MARK1 : LVL_MARK0);
            ST_DATA_WAIT: lvl = LVL_SPACE;
            ST_ULPS_HOLD: lvl = LVL_SPACE;
            ST_WAKE:      lvl = LVL_MARK1;
            ST_EXIT:      lvl = LVL_MARK1;
            default:      lvl = LVL_STOP;
        endcase
        return lvl;
    endfunction

    // Entry command selection: ULPS over LPDT over triggers, lowest trigger bit wins.
    always_comb begin
        anyMode = TxUlpsEsc || TxLpdtEsc || (|TxTriggerEsc);
        if (TxTriggerEsc[0])      trigCmd = 8'h62;
        else if (TxTriggerEsc[1]) trigCmd = 8'h5D;
        else if (TxTriggerEsc[2]) trigCmd = 8'h21;
        else                      trigCmd = 8'hA0;
        if (TxUlpsEsc)            entryCmd = 8'h1E;
        else if (TxLpdtEsc)       entryCmd = 8'hE1;
        else                      entryCmd = trigCmd;
    end

    // Next-state logic for the escape sequencer.
    always_comb begin
        stateNext   = stateReg;
        modeNext    = modeReg;
        bitCntNext  = bitCntReg;
        shiftNext   = shiftReg;
        wakeCntNext = wakeCntReg;
        case (stateReg)
            ST_STOP: begin
                if (TxRequestEsc && anyMode) begin
                    stateNext  = ST_ENT1;
                    bitCntNext = 4'd0;
                    shiftNext  = entryCmd;
                    if (TxUlpsEsc)      modeNext = MODE_ULPS;
                    else if (TxLpdtEsc) modeNext = MODE_LPDT;
                    else                modeNext = MODE_TRIG;
                end
            end
            ST_ENT1: stateNext = ST_ENT2;
            ST_ENT2: stateNext = ST_ENT3;
            ST_ENT3: stateNext = ST_ENT4;
            ST_ENT4: begin
                stateNext  = ST_CMD;
                bitCntNext = 4'd0;
            end
            ST_CMD: begin
                bitCntNext = bitCntReg + 4'd1;
                if (bitCntReg[0]) shiftNext = {shiftReg[6:0], 1'b0};
                if (bitCntReg == 4'd15) begin
                    case (modeReg)
                        MODE_LPDT: stateNext = ST_DATA_WAIT;
                        MODE_ULPS: stateNext = ST_ULPS_HOLD;
                        default:   stateNext = ST_EXIT;
                    endcase
                end
            end
            ST_DATA_WAIT: begin
                if (TxValidEsc) begin
                    stateNext  = ST_DATA;
                    shiftNext  = TxDataEsc;
                    bitCntNext = 4'd0;
                end else if (!TxRequestEsc) begin
                    stateNext = ST_EXIT;
                end
            end
            ST_DATA: begin
                bitCntNext = bitCntReg + 4'd1;
                if (bitCntReg[0]) shiftNext = {1'b0, shiftReg[7:1]};
                if (bitCntReg == 4'd15) stateNext = ST_DATA_WAIT;
            end
            ST_ULPS_HOLD: begin
                if (!TxRequestEsc) begin
                    stateNext   = ST_WAKE;
                    wakeCntNext = '0;
                end
            end
            ST_WAKE: begin
                if (wakeCntReg == WAKE_LAST) stateNext = ST_STOP;
                else                         wakeCntNext = wakeCntReg + WAKE_W'(1);
            end
            ST_EXIT: stateNext = ST_STOP;
            default: stateNext = ST_STOP;
        endcase
        linesNext = lineLevel(stateNext, shiftNext, bitCntNext);
    end

    // State and registered line/status outputs.
    always_ff @(posedge TxClkEsc) begin
        if (Rst) begin
            stateReg   <= ST_STOP;
            modeReg    <= MODE_LPDT;
            bitCntReg  <= 4'd0;
            shiftReg   <= 8'd0;
            wakeCntReg <= '0;
            linesReg   <= LVL_STOP;
            stopReg    <= 1'b1;
            ulpsNotReg <= 1'b1;
        end else begin
            stateReg   <= stateNext;
            modeReg    <= modeNext;
            bitCntReg  <= bitCntNext;
            shiftReg   <= shiftNext;
            wakeCntReg <= wakeCntNext;
            linesReg   <= linesNext;
            stopReg    <= (stateNext == ST_STOP);
            ulpsNotReg <= !((stateNext == ST_ULPS_HOLD) || (stateNext == ST_WAKE));
        end
    end

    // Byte handshake: only a DATA_WAIT cycle with valid data accepts a byte.
    always_comb begin
        TxReadyEsc = (stateReg == ST_DATA_WAIT) && TxValidEsc;
    end

    assign LpA           = linesReg[2];
    assign LpB           = linesReg[1];
    assign LpC           = linesReg[0];
    assign Stopstate     = stopReg;
    assign UlpsActiveNot = ulpsNotReg;

endmodule

// File: tb/tb_cphy_lp_escape_tx.sv
// Self-checking bench for cphy_lp_escape_tx. Each scripted cycle pushes the
// expected {A,B,C,TxReadyEsc,Stopstate,UlpsActiveNot} into a scoreboard queue;
// a monitor pops and compares one entry per clock on the falling edge.
module tb_cphy_lp_escape_tx;

    logic       TxClkEsc = 1'b0;
    logic       Rst;
    logic       TxRequestEsc;
    logic       TxLpdtEsc;
    logic       TxUlpsEsc;
    logic [3:0] TxTriggerEsc;
    logic [7:0] TxDataEsc;
    logic       TxValidEsc;
    logic       TxReadyEsc;
    logic       LpA;
    logic       LpB;
    logic       LpC;
    logic       Stopstate;
    logic       UlpsActiveNot;

    cphy_lp_escape_tx #(.WAKEUP_CYCLES(16)) dut (
        .TxClkEsc     (TxClkEsc),
        .Rst          (Rst),
        .TxRequestEsc (TxRequestEsc),
        .TxLpdtEsc    (TxLpdtEsc),
        .TxUlpsEsc    (TxUlpsEsc),
        .TxTriggerEsc (TxTriggerEsc),
        .TxDataEsc    (TxDataEsc),
        .TxValidEsc   (TxValidEsc),
        .TxReadyEsc   (TxReadyEsc),
        .LpA          (LpA),
        .LpB          (LpB),
        .LpC          (LpC),
        .Stopstate    (Stopstate),
        .UlpsActiveNot(UlpsActiveNot)
    );

    always #5 TxClkEsc = ~TxClkEsc;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] expQ[$];
    string      tagQ[$];
    string      curTag;
    int         cycIdx;
    int         toggles = 0;
    logic       prevAc = 1'b0;
    logic [5:0] monExp;
    string      monTag;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor plus A^C toggle counter.
    always @(negedge TxClkEsc) begin
        if ((LpA ^ LpC) !== prevAc) toggles++;
        prevAc = LpA ^ LpC;
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            monTag = tagQ.pop_front();
            checkEq(monTag, 32'({LpA, LpB, LpC, TxReadyEsc, Stopstate, UlpsActiveNot}), 32'(monExp));
        end
    end

    // One cycle: expectation for the cycle now starting, then advance.
    task automatic cyc(input logic [2:0] ln, input logic rdy, input logic stp, input logic uln);
        expQ.push_back({ln, rdy, stp, uln});
        tagQ.push_back($sformatf("%s_c%0d", curTag, cycIdx));
        cycIdx++;
        @(posedge TxClkEsc);
        #1;
    endtask

    task automatic mark(input logic b);
        cyc(b ? 3'b100 : 3'b001, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic space();
        cyc(3'b000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic entry();
        cyc(3'b100, 1'b0, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b0, 1'b1);
        cyc(3'b001, 1'b0, 1'b0, 1'b1);
        cyc(3'b000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic sendCmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) begin
            mark(c[i]);
            space();
        end
    endtask

    task automatic sendData(input logic [7:0] d);
        toggles = 0;
        for (int i = 0; i < 8; i++) begin
            mark(d[i]);
            space();
        end
        checkEq({curTag, "_toggles"}, 32'(toggles), 32'd16);
    endtask

    task automatic startTest(input string t);
        curTag = t;
        cycIdx = 0;
    endtask

    task automatic endTest();
        $display("[%s] transaction done: %0d cycles, checks so far %0d, errors so far %0d",
                 curTag, cycIdx, checks, errors);
    endtask

    task automatic stopCyc();
        cyc(3'b111, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst = 1'b1; TxRequestEsc = 1'b0; TxLpdtEsc = 1'b0; TxUlpsEsc = 1'b0;
        TxTriggerEsc = 4'd0; TxDataEsc = 8'd0; TxValidEsc = 1'b0;
        @(posedge TxClkEsc);
        #1;

        // Reset values, then request without any mode stays in STOP
        startTest("reset");
        stopCyc(); stopCyc();
        Rst = 1'b0;
        stopCyc();
        TxRequestEsc = 1'b1;
        stopCyc(); stopCyc();
        TxRequestEsc = 1'b0;
        stopCyc();
        endTest();

        // 1: LPDT single byte A5
        startTest("t1_lpdt_a5");
        TxRequestEsc = 1'b1; TxLpdtEsc = 1'b1;
        stopCyc();
        TxLpdtEsc = 1'b0;
        entry();
        sendCmd(8'hE1);
        TxValidEsc = 1'b1; TxDataEsc = 8'hA5;
        cyc(3'b000, 1'b1, 1'b0, 1'b1);
        TxValidEsc = 1'b0; TxRequestEsc = 1'b0;
        sendData(8'hA5);
        cyc(3'b000, 1'b0, 1'b0, 1'b1);
        cyc(3'b100, 1'b0, 1'b0, 1'b1);
        stopCyc();
        endTest();

        // 2: back-to-back 00 and FF
        startTest("t2_b2b");
        TxRequestEsc = 1'b1; TxLpdtEsc = 1'b1;
        stopCyc();
        TxLpdtEsc = 1'b0;
        entry();
        sendCmd(8'hE1);
        TxValidEsc = 1'b1; TxDataEsc = 8'h00;
        cyc(3'b000, 1'b1, 1'b0, 1'b1);
        TxDataEsc = 8'hFF;
        sendData(8'h00);
        cyc(3'b000, 1'b1, 1'b0, 1'b1);
        TxValidEsc = 1'b0; TxRequestEsc = 1'b0;
        sendData(8'hFF);
        cyc(3'b000, 1'b0, 1'b0, 1'b1);
        cyc(3'b100, 1'b0, 1'b0, 1'b1);
        stopCyc();
        endTest();

        // 3: line pause of 5 cycles between bytes
        startTest("t3_pause");
        TxRequestEsc = 1'b1; TxLpdtEsc = 1'b1;
        stopCyc();
        TxLpdtEsc = 1'b0;
        entry();
        sendCmd(8'hE1);
        TxValidEsc = 1'b1; TxDataEsc = 8'h3C;
        cyc(3'b000, 1'b1, 1'b0, 1'b1);
        TxValidEsc = 1'b0;
        sendData(8'h3C);
        repeat (5) cyc(3'b000, 1'b0, 1'b0, 1'b1);
        TxValidEsc = 1'b1; TxDataEsc = 8'hC3;
        cyc(3'b000, 1'b1, 1'b0, 1'b1);
        TxValidEsc = 1'b0; TxRequestEsc = 1'b0;
        sendData(8'hC3);
        cyc(3'b000, 1'b0, 1'b0, 1'b1);
        cyc(3'b100, 1'b0, 1'b0, 1'b1);
        stopCyc();
        endTest();

        // 4: ULPS held 10 cycles, then wakeup
        startTest("t4_ulps");
        TxRequestEsc = 1'b1; TxUlpsEsc = 1'b1;
        stopCyc();
        TxUlpsEsc = 1'b0;
        entry();
        sendCmd(8'h1E);
        repeat (10) cyc(3'b000, 1'b0, 1'b0, 1'b0);
        TxRequestEsc = 1'b0;
        cyc(3'b000, 1'b0, 1'b0, 1'b0);
        repeat (16) cyc(3'b100, 1'b0, 1'b0, 1'b0);
        stopCyc();
        endTest();

        // 5a: trigger 0110 -> bit1 command 5D
        startTest("t5_trig");
        TxRequestEsc = 1'b1; TxTriggerEsc = 4'b0110;
        stopCyc();
        TxTriggerEsc = 4'b0000;
        entry();
        TxRequestEsc = 1'b0;
        sendCmd(8'h5D);
        cyc(3'b100, 1'b0, 1'b0, 1'b1);
        stopCyc();
        endTest();

        // 5b: ULPS wins over LPDT and triggers; request drop during entry ignored
        startTest("t5_prio");
        TxRequestEsc = 1'b1; TxUlpsEsc = 1'b1; TxLpdtEsc = 1'b1; TxTriggerEsc = 4'b0110;
        stopCyc();
        TxUlpsEsc = 1'b0; TxLpdtEsc = 1'b0; TxTriggerEsc = 4'b0000;
        TxRequestEsc = 1'b0;
        entry();
        sendCmd(8'h1E);
        cyc(3'b000, 1'b0, 1'b0, 1'b0);
        repeat (16) cyc(3'b100, 1'b0, 1'b0, 1'b0);
        stopCyc();
        endTest();

        // 6: reset during bit 3 of byte 5A, then clean restart
        startTest("t6_rst");
        TxRequestEsc = 1'b1; TxLpdtEsc = 1'b1;
        stopCyc();
        TxLpdtEsc = 1'b0;
        entry();
        sendCmd(8'hE1);
        TxValidEsc = 1'b1; TxDataEsc = 8'h5A;
        cyc(3'b000, 1'b1, 1'b0, 1'b1);
        mark(1'b0); space();
        mark(1'b1); space();
        mark(1'b0); space();
        Rst = 1'b1;
        mark(1'b1);
        Rst = 1'b0; TxLpdtEsc = 1'b1;
        stopCyc();
        TxLpdtEsc = 1'b0;
        entry();
        sendCmd(8'hE1);
        TxValidEsc = 1'b0; TxRequestEsc = 1'b0;
        cyc(3'b000, 1'b0, 1'b0, 1'b1);
        cyc(3'b100, 1'b0, 1'b0, 1'b1);
        stopCyc();
        endTest();

        repeat (2) @(posedge TxClkEsc);
        #1;
        checkEq("queue_drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
